food_placer: RTL and testbench
==============================

# food_placer

Food-position generator for the 8x8 snake board. Downstream of the strobe sequencer: it consumes the `clk_food` and `clk_eightxeight` strobes, and returns `food_collision` and `food_collision_replace`. On each `clk_food` rising edge it draws a pseudo-random cell and commits it only if the snake does not occupy it. It retries on further strobes, and falls back to a linear scan so that placement always terminates.

## Interface
- `SEED`, 8'hB5, LFSR reset value; must be nonzero.
- `INIT_X`, 3'd5, food column after reset.
- `INIT_Y`, 3'd5, food row after reset.
- `MAX_TRIES`, 4, random draws allowed before the scan fallback; range 1..15.

- `clk_master`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low; 0 resets all state.
- `clk_food`  in  1  placement strobe from the sequencer. The sequencer toggles it every cycle while `food_collision_replace`=1.
- `clk_eightxeight`  in  1  head-check strobe.
- `board`  in  64  snake occupancy map; bit index = {y,x}.
- `head_x`, `head_y`  in  3 each  current head cell.
- `food_x`, `food_y`  out  3 each  committed food cell.
- `food_valid`  out  1  food is present on the board.
- `food_map`  out  64  one-hot of {food_y,food_x}; all-zero when `food_valid`=0.
- `food_collision`  out  1  registered head==food result.
- `food_collision_replace`  out  1  combinational; 1 = placement not yet committed.
- `board_full`  out  1  sticky; no free cell existed at the last placement attempt.

## Operation
- **LFSR**
  - 8-bit, free-running, advances every cycle: next = {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
  - `cand` = lfsr[5:0]; `occ` = board[cand].
- **Edge detection**
  - `rise` = clk_food & ~clk_food_d, where clk_food_d is a 1-cycle delayed copy.
  - `eig_rise` is defined the same way for `clk_eightxeight`.
- **States:** IDLE, RETRY, SCAN. Registers are `tries` (4b) and `scan_idx` (6b).
- **IDLE**
  - If &board on `rise`: board_full<=1, food_valid<=0, food_collision<=0; state stays IDLE; replace=0.
  - Else if `rise` & ~occ: commit `cand`.
  - Else if `rise` & occ: tries<=1 and go to RETRY; replace=1 in that cycle.
  - Otherwise replace=0.
- **RETRY**
  - replace = ~(rise & ~occ).
  - `rise` & ~occ: commit `cand` and go to IDLE.
  - `rise` & occ & tries==MAX_TRIES-1: scan_idx<=cand+1 and go to SCAN.
  - `rise` & occ otherwise: tries<=tries+1.
  - No `rise`: hold.
- **SCAN**
  - replace = board[scan_idx].
  - board[scan_idx]==0: commit scan_idx and go to IDLE.
  - Otherwise scan_idx<=scan_idx+1 (6-bit wrap, 63→0). A `rise` is ignored.
- **Commit (one edge)**
  - {food_y,food_x}<=index, food_valid<=1, board_full<=0, food_collision<=0, tries<=0.
- **Head check**
  - On `eig_rise`: food_collision <= food_valid & ({head_y,head_x}=={food_y,food_x}).
  - Otherwise food_collision holds.
  - If commit and `eig_rise` occur in the same cycle, commit wins and food_collision becomes 0.
- **Board full mid-placement:** if &board in RETRY or SCAN, board_full<=1, food_valid<=0, go to IDLE, replace=0 that cycle.
- **`board` sampling:** `board` is sampled live. Any change during RETRY/SCAN takes effect on the next comparison.

## Timing
- **Reset values**
  - lfsr=SEED, food_x=INIT_X, food_y=INIT_Y, food_valid=1, food_map bit 45 set.
  - food_collision=0, board_full=0, state=IDLE, tries=0, scan_idx=0, clk_food_d=0, clk_eightxeight_d=0.
  - food_collision_replace=0 while reset is low.
- **Reset mid-operation:** reset asserted in any state returns all state to these values immediately (asynchronous). The sequencer then sees replace=0.
- **`food_collision_replace` path**
  - It is valid in the same cycle as the `clk_food` rising level, because it is combinational from registered state, `lfsr` and `board`.
  - The sequencer samples it at the next edge.
- **Latency**
  - Successful draw: food outputs update at the edge ending the `rise` cycle.
  - Retry: one draw per 2 cycles (toggle rate).
  - Worst-case placement: 2·MAX_TRIES + 64 cycles.
- **food_collision latency:** updates at the edge ending the `eig_rise` cycle, one cycle before the sequencer's collision decision edge.

## Test plan
- **Reset:** release reset → food (5,5), food_valid=1, food_map=64'h0000_2000_0000_0000, food_collision=0, replace=0.
- **Free draw:** board=0, `clk_food` high for 1 cycle → replace=0 throughout. Next cycle {food_y,food_x} equals the `cand` sampled in the pulse cycle; food_map is one-hot at that index.
- **Scan fallback:** MAX_TRIES=4, board all ones except bit 37. Bench toggles `clk_food` while replace=1 → commit at (x=5,y=4), replace falls in the commit cycle, within 72 cycles.
- **Board full:** board=all ones, pulse `clk_food` → replace=0, board_full=1, food_valid=0, food_map=0. Clear bit 0 and pulse again → food (0,0), board_full=0.
- **Head check:** after reset, head (5,5), pulse `clk_eightxeight` → food_collision=1 next cycle. Head (6,5), pulse → 0. Commit coinciding with a pulse → 0.
- **Reset mid-scan:** pull reset low during SCAN → replace=0 and food (5,5) immediately. After release, state=IDLE and tries=0.

Source files
------------

// File: rtl/food_placer.sv
// rtl/food_placer.sv - food position generator for the 8x8 snake board
// Random draw with retries on clk_food strobes, falling back to a linear scan of the board.
module food_placer #(
  parameter logic [7:0]  SEED      = 8'hB5,
  parameter logic [2:0]  INIT_X    = 3'd5,
  parameter logic [2:0]  INIT_Y    = 3'd5,
  parameter int unsigned MAX_TRIES = 4
) (
  input  logic        clk_master,
  input  logic        reset,
  input  logic        clk_food,
  input  logic        clk_eightxeight,
  input  logic [63:0] board,
  input  logic [2:0]  head_x,
  input  logic [2:0]  head_y,
  output logic [2:0]  food_x,
  output logic [2:0]  food_y,
  output logic        food_valid,
  output logic [63:0] food_map,
  output logic        food_collision,
  output logic        food_collision_replace,
  output logic        board_full
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RETRY = 2'd1,
    SCAN  = 2'd2
  } state_t;

  localparam logic [3:0] LAST_TRY = 4'(MAX_TRIES - 1);

  state_t      state;
  logic [7:0]  lfsr;
  logic [7:0]  lfsr_next;
  logic [3:0]  tries;
  logic [5:0]  scan_idx;
  logic        clk_food_d;
  logic        clk_eightxeight_d;

  logic [5:0]  cand;
  logic        occ;
  logic        scan_occ;
  logic        full;
  logic        rise;
  logic        eig_rise;
  logic        commit;
  logic [5:0]  commit_idx;

  assign lfsr_next = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  assign cand      = lfsr[5:0];
  assign occ       = board[cand];
  assign scan_occ  = board[scan_idx];
  assign full      = &board;
  assign rise      = clk_food & ~clk_food_d;
  assign eig_rise  = clk_eightxeight & ~clk_eightxeight_d;

  // Gated by reset so the sequencer never sees a pending placement while held in reset.
  always_comb begin
    food_collision_replace = 1'b0;
    if (reset) begin
      case (state)
        IDLE:    food_collision_replace = rise & occ & ~full;
        RETRY:   food_collision_replace = ~full & ~(rise & ~occ);
        SCAN:    food_collision_replace = ~full & scan_occ;
        default: food_collision_replace = 1'b0;
      endcase
    end
  end

  always_comb begin
    commit     = 1'b0;
    commit_idx = cand;
    case (state)
      IDLE:    commit = rise & ~full & ~occ;
      RETRY:   commit = rise & ~full & ~occ;
      SCAN: begin
        commit     = ~full & ~scan_occ;
        commit_idx = scan_idx;
      end
      default: commit = 1'b0;
    endcase
  end

  always_comb begin
    food_map = '0;
    if (food_valid) food_map[{food_y, food_x}] = 1'b1;
  end

  always_ff @(posedge clk_master or negedge reset) begin
    if (!reset) begin
      state             <= IDLE;
      lfsr              <= SEED;
      tries             <= '0;
      scan_idx          <= '0;
      clk_food_d        <= 1'b0;
      clk_eightxeight_d <= 1'b0;
      food_x            <= INIT_X;
      food_y            <= INIT_Y;
      food_valid        <= 1'b1;
      food_collision    <= 1'b0;
      board_full        <= 1'b0;
    end else begin
      lfsr              <= lfsr_next;
      clk_food_d        <= clk_food;
      clk_eightxeight_d <= clk_eightxeight;

      if (eig_rise) food_collision <= food_valid & ({head_y, head_x} == {food_y, food_x});

      // A commit overrides the head check issued in the same cycle.
      if (commit) begin
        {food_y, food_x} <= commit_idx;
        food_valid       <= 1'b1;
        board_full       <= 1'b0;
        food_collision   <= 1'b0;
        tries            <= '0;
        state            <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (rise && full) begin
              board_full     <= 1'b1;
              food_valid     <= 1'b0;
              food_collision <= 1'b0;
            end else if (rise && occ) begin
              tries <= 4'd1;
              state <= RETRY;
            end
          end
          RETRY: begin
            if (full) begin
              board_full <= 1'b1;
              food_valid <= 1'b0;
              state      <= IDLE;
            end else if (rise) begin
              if (tries >= LAST_TRY) begin
                scan_idx <= cand + 6'd1;
                state    <= SCAN;
              end else begin
                tries <= tries + 4'd1;
              end
            end
          end
          SCAN: begin
            if (full) begin
              board_full <= 1'b1;
              food_valid <= 1'b0;
              state      <= IDLE;
            end else begin
              scan_idx <= scan_idx + 6'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_food_placer.sv
// tb/tb_food_placer.sv - bench for food_placer
// Vector table, directed corner sequences and a randomized run against a reference model.
module tb_food_placer;

  localparam logic [7:0] SEED      = 8'hB5;
  localparam int         MAX_TRIES = 4;
  localparam int         M_IDLE = 0, M_RETRY = 1, M_SCAN = 2;

  logic        clk_master = 1'b0;
  logic        reset = 1'b0;
  logic        clk_food = 1'b0;
  logic        clk_eightxeight = 1'b0;
  logic [63:0] board = '0;
  logic [2:0]  head_x = '0;
  logic [2:0]  head_y = '0;
  logic [2:0]  food_x, food_y;
  logic        food_valid, food_collision, food_collision_replace, board_full;
  logic [63:0] food_map;

  food_placer #(.SEED(SEED), .INIT_X(3'd5), .INIT_Y(3'd5), .MAX_TRIES(MAX_TRIES)) dut (
    .clk_master(clk_master), .reset(reset), .clk_food(clk_food),
    .clk_eightxeight(clk_eightxeight), .board(board), .head_x(head_x), .head_y(head_y),
    .food_x(food_x), .food_y(food_y), .food_valid(food_valid), .food_map(food_map),
    .food_collision(food_collision), .food_collision_replace(food_collision_replace),
    .board_full(board_full)
  );

  always #5 clk_master = ~clk_master;

  int errors = 0;
  int checks = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: placement described as draws, a draw budget and a scan pointer.
  logic [7:0] m_lfsr, n_lfsr;
  int m_mode, n_mode, m_draws, n_draws, m_scan, n_scan, m_food, n_food;
  bit m_valid, n_valid, m_coll, n_coll, m_full, n_full, m_cf_d, n_cf_d, m_ce_d, n_ce_d;
  bit exp_rep;

  function automatic logic [7:0] lfsr_step(logic [7:0] v);
    return {v[6:0], ^(v & 8'hB8)};
  endfunction

  task automatic model_reset();
    m_lfsr = SEED; m_mode = M_IDLE; m_draws = 0; m_scan = 0; m_food = 45;
    m_valid = 1; m_coll = 0; m_full = 0; m_cf_d = 0; m_ce_d = 0; exp_rep = 0;
  endtask

  task automatic model_predict();
    bit rise, erise, full, occ;
    int cand, idx;
    rise  = clk_food && !m_cf_d;
    erise = clk_eightxeight && !m_ce_d;
    cand  = int'(m_lfsr[5:0]);
    occ   = board[cand];
    full  = (board == {64{1'b1}});
    n_lfsr = lfsr_step(m_lfsr); n_mode = m_mode; n_draws = m_draws; n_scan = m_scan;
    n_food = m_food; n_valid = m_valid; n_coll = m_coll; n_full = m_full;
    n_cf_d = clk_food; n_ce_d = clk_eightxeight;
    if (erise) n_coll = m_valid && (int'(head_y) * 8 + int'(head_x) == m_food);
    exp_rep = 0;
    idx = -1;
    if (m_mode == M_IDLE) begin
      if (rise && full) begin n_full = 1; n_valid = 0; n_coll = 0; end
      else if (rise && !occ) idx = cand;
      else if (rise) begin n_draws = 1; n_mode = M_RETRY; exp_rep = 1; end
    end else if (full) begin
      n_full = 1; n_valid = 0; n_mode = M_IDLE;
    end else if (m_mode == M_RETRY) begin
      if (!rise) exp_rep = 1;
      else if (!occ) idx = cand;
      else begin
        exp_rep = 1;
        if (m_draws + 1 >= MAX_TRIES) begin n_scan = (cand + 1) % 64; n_mode = M_SCAN; end
        else n_draws = m_draws + 1;
      end
    end else begin
      if (!board[m_scan]) idx = m_scan;
      else begin exp_rep = 1; n_scan = (m_scan + 1) % 64; end
    end
    if (idx >= 0) begin
      n_food = idx; n_valid = 1; n_full = 0; n_coll = 0; n_draws = 0; n_mode = M_IDLE;
    end
  endtask

  task automatic model_advance();
    m_lfsr = n_lfsr; m_mode = n_mode; m_draws = n_draws; m_scan = n_scan; m_food = n_food;
    m_valid = n_valid; m_coll = n_coll; m_full = n_full; m_cf_d = n_cf_d; m_ce_d = n_ce_d;
  endtask

  task automatic cycle();
    logic [63:0] emap;
    #1;
    model_predict();
    chk("replace", 64'(food_collision_replace), 64'(exp_rep));
    @(posedge clk_master); #1;
    model_advance();
    emap = m_valid ? (64'd1 << m_food) : 64'd0;
    chk("food_x", 64'(food_x), 64'(m_food % 8));
    chk("food_y", 64'(food_y), 64'(m_food / 8));
    chk("food_valid", 64'(food_valid), 64'(m_valid));
    chk("food_map", food_map, emap);
    chk("collision", 64'(food_collision), 64'(m_coll));
    chk("board_full", 64'(board_full), 64'(m_full));
  endtask

  task automatic do_reset();
    reset = 1'b0; clk_food = 1'b0; clk_eightxeight = 1'b0;
    @(posedge clk_master); #1;
    chk("rst_replace", 64'(food_collision_replace), 64'd0);
    chk("rst_food_map", food_map, 64'h0000_2000_0000_0000);
    chk("rst_valid", 64'(food_valid), 64'd1);
    chk("rst_collision", 64'(food_collision), 64'd0);
    chk("rst_full", 64'(board_full), 64'd0);
    reset = 1'b1;
    model_reset();
  endtask

  typedef struct packed {
    logic [63:0] brd;
    logic        cf, ce;
    logic [2:0]  hx, hy;
    logic        rep;
    logic [6:0]  fidx;   // 0..63 fixed cell, 64 = draw of this cycle, 65 = unchanged
    logic        valid, coll, full;
  } vec_t;

  function automatic vec_t mk(logic [63:0] b, logic cf, logic ce, logic [2:0] hx, logic [2:0] hy,
                              logic rep, logic [6:0] fi, logic v, logic c, logic f);
    return '{b, cf, ce, hx, hy, rep, fi, v, c, f};
  endfunction

  localparam logic [63:0] ONES = {64{1'b1}};
  vec_t vecs[14];

  initial begin
    int n, a, b, tbl_food, exp_idx;
    logic [63:0] emap;

    vecs[0]  = mk(64'd0, 0, 0, 3'd0, 3'd0, 0, 7'd45, 1, 0, 0);
    vecs[1]  = mk(64'd0, 0, 1, 3'd5, 3'd5, 0, 7'd45, 1, 1, 0);
    vecs[2]  = mk(64'd0, 0, 0, 3'd6, 3'd5, 0, 7'd45, 1, 1, 0);
    vecs[3]  = mk(64'd0, 0, 1, 3'd6, 3'd5, 0, 7'd45, 1, 0, 0);
    vecs[4]  = mk(64'd0, 0, 0, 3'd5, 3'd5, 0, 7'd45, 1, 0, 0);
    vecs[5]  = mk(64'd0, 0, 1, 3'd5, 3'd5, 0, 7'd45, 1, 1, 0);
    vecs[6]  = mk(64'd0, 0, 0, 3'd5, 3'd5, 0, 7'd45, 1, 1, 0);
    vecs[7]  = mk(64'd0, 1, 1, 3'd5, 3'd5, 0, 7'd64, 1, 0, 0);
    vecs[8]  = mk(64'd0, 0, 0, 3'd5, 3'd5, 0, 7'd65, 1, 0, 0);
    vecs[9]  = mk(ONES,  1, 0, 3'd5, 3'd5, 0, 7'd65, 0, 0, 1);
    vecs[10] = mk(ONES,  0, 1, 3'd0, 3'd0, 0, 7'd65, 0, 0, 1);
    vecs[11] = mk(ONES,  1, 0, 3'd0, 3'd0, 0, 7'd65, 0, 0, 1);
    vecs[12] = mk(64'd0, 0, 0, 3'd0, 3'd0, 0, 7'd65, 0, 0, 1);
    vecs[13] = mk(64'd0, 1, 0, 3'd0, 3'd0, 0, 7'd64, 1, 0, 0);

    do_reset();
    tbl_food = 45;
    for (int i = 0; i < 14; i++) begin
      board = vecs[i].brd; clk_food = vecs[i].cf; clk_eightxeight = vecs[i].ce;
      head_x = vecs[i].hx; head_y = vecs[i].hy;
      #1;
      model_predict();
      exp_idx = (vecs[i].fidx == 7'd64) ? int'(m_lfsr[5:0]) :
                (vecs[i].fidx == 7'd65) ? tbl_food : int'(vecs[i].fidx);
      chk($sformatf("vec%0d_replace", i), 64'(food_collision_replace), 64'(vecs[i].rep));
      @(posedge clk_master); #1;
      model_advance();
      tbl_food = exp_idx;
      emap = vecs[i].valid ? (64'd1 << exp_idx) : 64'd0;
      chk($sformatf("vec%0d_food_x", i), 64'(food_x), 64'(exp_idx % 8));
      chk($sformatf("vec%0d_food_y", i), 64'(food_y), 64'(exp_idx / 8));
      chk($sformatf("vec%0d_valid", i), 64'(food_valid), 64'(vecs[i].valid));
      chk($sformatf("vec%0d_map", i), food_map, emap);
      chk($sformatf("vec%0d_collision", i), 64'(food_collision), 64'(vecs[i].coll));
      chk($sformatf("vec%0d_full", i), 64'(board_full), 64'(vecs[i].full));
    end

    // Board full, then free only cell 0: placement must land on (0,0).
    clk_food = 0; clk_eightxeight = 0; board = ONES; cycle();
    clk_food = 1; cycle();
    chk("full_flag", 64'(board_full), 64'd1);
    chk("full_map", food_map, 64'd0);
    board = ~64'd1; clk_food = 0; cycle();
    clk_food = 1; cycle();
    n = 0;
    while (!(m_valid && m_food == 0) && n < 200) begin
      clk_food = exp_rep ? ~clk_food : 1'b0; cycle(); n++;
    end
    chk("cell0_bound", 64'(n < 200), 64'd1);
    chk("cell0_x", 64'(food_x), 64'd0);
    chk("cell0_y", 64'(food_y), 64'd0);
    chk("cell0_full", 64'(board_full), 64'd0);

    // Scan fallback: only cell 37 free, bounded by 2*MAX_TRIES+64 cycles.
    do_reset();
    board = ~(64'd1 << 37); clk_food = 1; cycle();
    n = 1;
    while (!(food_x == 3'd5 && food_y == 3'd4) && n < 100) begin
      clk_food = exp_rep ? ~clk_food : 1'b0; cycle(); n++;
    end
    chk("scan_latency", 64'(n <= 2 * MAX_TRIES + 64), 64'd1);
    chk("scan_x", 64'(food_x), 64'd5);
    chk("scan_y", 64'(food_y), 64'd4);
    chk("scan_replace_low", 64'(food_collision_replace), 64'd0);

    // Asynchronous reset while scanning.
    do_reset();
    board = ~(64'd1 << 2); clk_food = 1; cycle();
    n = 0;
    while (m_mode != M_SCAN && n < 50) begin
      clk_food = exp_rep ? ~clk_food : 1'b0; cycle(); n++;
    end
    chk("reach_scan", 64'(n < 50), 64'd1);
    #2 reset = 1'b0; clk_food = 1'b1; #1;
    chk("midrst_replace", 64'(food_collision_replace), 64'd0);
    chk("midrst_x", 64'(food_x), 64'd5);
    chk("midrst_y", 64'(food_y), 64'd5);
    chk("midrst_valid", 64'(food_valid), 64'd1);
    model_reset();
    @(negedge clk_master); reset = 1'b1; clk_food = 1'b0; board = ~(64'd1 << 2);
    cycle();
    clk_food = 1; cycle();
    n = 0;
    while (!(m_valid && m_food == 2) && n < 100) begin
      clk_food = exp_rep ? ~clk_food : 1'b0; cycle(); n++;
    end
    chk("post_rst_place", 64'({food_y, food_x}), 64'd2);

    // Randomized traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      if (k % 150 == 0) begin
        a = $urandom_range(0, 63); b = $urandom_range(0, 63);
        case ($urandom_range(0, 4))
          0: board = {$urandom, $urandom} & {$urandom, $urandom};
          1: board = {$urandom, $urandom};
          2: board = ~(64'd1 << a);
          3: board = ONES;
          default: board = ~((64'd1 << a) | (64'd1 << b));
        endcase
      end else if ($urandom_range(0, 59) == 0) begin
        board[$urandom_range(0, 63)] ^= 1'b1;
      end
      if (exp_rep) clk_food = ~clk_food;
      else clk_food = !clk_food && ($urandom_range(0, 3) == 0);
      clk_eightxeight = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 3) == 0) begin head_x = 3'(m_food % 8); head_y = 3'(m_food / 8); end
      else if ($urandom_range(0, 3) == 0) begin head_x = 3'($urandom); head_y = 3'($urandom); end
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
